fp_sqrt_nr_ctrl: RTL

- Sequencer that computes the IEEE-754 single-precision square root of one operand by Newton-Raphson iteration: x(n+1) = (x(n) + a/x(n)) / 2.
- Time-shares the existing combinational FP divider (new_div) and an external FP adder. Both are driven through ports.
- Halving is an exponent decrement done inside this block.
- Sits between the SQRT top-level request interface and the shared arithmetic units.

---
 rtl/fp_sqrt_nr_ctrl_if.sv | 17 +
 rtl/fp_sqrt_nr_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/fp_sqrt_nr_ctrl_if.sv
// fp_sqrt_nr_ctrl_if: request handshake and shared divider/adder bundle for the sqrt sequencer
interface fp_sqrt_nr_ctrl_if;
   logic        start;
   logic [31:0] a_in;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_q;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic [31:0] add_s;
   modport master (output start, a_in, div_q, add_s, input ready, busy, done, result, div_a, div_b, add_a, add_b);
   modport slave (input start, a_in, div_q, add_s, output ready, busy, done, result, div_a, div_b, add_a, add_b);
endinterface

// File: rtl/fp_sqrt_nr_ctrl.sv
// fp_sqrt_nr_ctrl: single-precision square root by Newton-Raphson over a shared divider and adder
module fp_sqrt_nr_ctrl #(
   parameter int ITER    = 4,
   parameter int DIV_LAT = 1,
   parameter int ADD_LAT = 1
) (
   input logic              clk,
   input logic              rst,
   fp_sqrt_nr_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DIV, ADD, DONE} state_t;
   state_t      state, state_nx;
   logic [31:0] a_reg, x, q_reg, res, seed, spec_res, x_half;
   logic [8:0]  seed_sum;
   logic [7:0]  a_exp, s_exp, lat_cnt;
   logic [3:0]  iter_cnt;
   logic        special, accept, div_last, add_last, last_iter;

   assign a_exp     = bus.a_in[30:23];
   assign special   = a_exp == 8'd0 || a_exp == 8'hff || bus.a_in[31];
   assign spec_res  = bus.a_in[30:0] == 31'd0 ? bus.a_in :
                      a_exp == 8'd0 ? 32'd0 :
                      bus.a_in == 32'h7f800000 ? 32'h7f800000 : 32'h7fc00000;
   assign seed_sum  = {1'b0, a_exp} + 9'd127;
   assign seed      = {1'b0, 8'(seed_sum >> 1), bus.a_in[22:0]};
   assign s_exp     = bus.add_s[30:23];
   assign x_half    = (bus.add_s[31] || s_exp <= 8'd1) ? 32'd0 : {1'b0, s_exp - 8'd1, bus.add_s[22:0]};
   assign accept    = state == IDLE && bus.start;
   assign div_last  = state == DIV && lat_cnt == 8'(DIV_LAT - 1);
   assign add_last  = state == ADD && lat_cnt == 8'(ADD_LAT - 1);
   assign last_iter = iter_cnt == 4'(ITER - 1);
   assign bus.ready  = state == IDLE;
   assign bus.busy   = state != IDLE;
   assign bus.done   = state == DONE;
   assign bus.result = res;

   // state register
   always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

   // next state and unit operand steering; operands stay zero unless their unit is in use
   always_comb begin
      state_nx  = state;
      bus.div_a = 32'd0;
      bus.div_b = 32'd0;
      bus.add_a = 32'd0;
      bus.add_b = 32'd0;
      unique case (state)
         IDLE: state_nx = bus.start ? (special ? DONE : DIV) : IDLE;
         DIV: begin
            bus.div_a = a_reg;
            bus.div_b = x;
            state_nx  = div_last ? ADD : DIV;
         end
         ADD: begin
            bus.add_a = x;
            bus.add_b = q_reg;
            state_nx  = add_last ? (last_iter ? DONE : DIV) : ADD;
         end
         DONE: state_nx = IDLE;
      endcase
   end

   // operand capture, iterate update and result latch
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg    <= 32'd0;
         x        <= 32'd0;
         q_reg    <= 32'd0;
         res      <= 32'd0;
         iter_cnt <= 4'd0;
         lat_cnt  <= 8'd0;
      end else begin
         lat_cnt <= ((state == DIV && !div_last) || (state == ADD && !add_last)) ? lat_cnt + 8'd1 : 8'd0;
         if (accept) begin
            a_reg    <= bus.a_in;
            x        <= seed;
            iter_cnt <= 4'd0;
            if (special) res <= spec_res;
         end
         if (div_last) q_reg <= bus.div_q;
         if (add_last) begin
            x        <= x_half;
            iter_cnt <= iter_cnt + 4'd1;
            if (last_iter) res <= x_half;
         end
      end
   end
endmodule
